// File: rtl/pe_traffic_gen.sv
// NoC endpoint: injects PKT_LEN-flit packets every INJ_PERIOD enabled cycles under per-VC credits; sinks flits and returns a credit one cycle later.
// Sends stall on the packet's VC (no mid-packet switch) while it has no credit or en is low; define PE_RX_CHECK_EN for the per-VC receive-order checker.
module pe_traffic_gen #(
  parameter int NUM_VCS        = 2,
  parameter int NUM_RECV_PORTS = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int BUF_DEPTH      = 4,
  parameter int PKT_LEN        = 4,
  parameter int INJ_PERIOD     = 20,
  localparam int VC_BITS   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int DEST_BITS = $clog2(NUM_RECV_PORTS),
  localparam int FLIT_W    = 2 + DEST_BITS + VC_BITS + DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DEST_BITS-1:0] cfg_dest,
  input  logic [FLIT_W-1:0]    flit_in,
  output logic [FLIT_W-1:0]    flit_out,
  output logic                 send_flit,
  input  logic [VC_BITS:0]     credit_in,
  output logic [VC_BITS:0]     credit_out,
  output logic                 send_credit,
  output logic [31:0]          tx_flits,
  output logic [31:0]          rx_flits,
  output logic                 credit_err,
  output logic                 rx_err
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int SEQ_W = DATA_WIDTH - 8;
  localparam int TMR_W = (INJ_PERIOD > 1) ? $clog2(INJ_PERIOD) : 1;

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;

  logic [TMR_W-1:0]     timer;
  logic                 pending;
  logic                 wrap;
  logic [CNT_W-1:0]     credit [NUM_VCS];
  logic [NUM_VCS-1:0]   cr_inc, cr_dec;
  logic [VC_BITS-1:0]   rr_ptr, cur_vc, pick_vc, hi_vc, any_vc;
  logic                 hi_ok, any_ok, pick_ok, cur_has_credit;
  logic [DEST_BITS-1:0] cur_dest;
  logic [7:0]           flit_idx;
  logic [SEQ_W-1:0]     pkt_seq;
  logic                 start, fire, is_tail;
  logic                 rx_vld;
  logic [VC_BITS-1:0]   rx_vc;
  logic                 unused_flit_bits;

  assign wrap    = en && (timer == TMR_W'(INJ_PERIOD - 1));
  assign is_tail = (flit_idx == 8'(PKT_LEN - 1));
  assign rx_vld  = flit_in[FLIT_W-1];
  assign rx_vc   = flit_in[DATA_WIDTH +: VC_BITS];
  assign unused_flit_bits = ^{flit_in[FLIT_W-2 -: 1+DEST_BITS], flit_in[DATA_WIDTH-1:0]};

  // Round-robin: lowest VC at/after rr_ptr with credit, else lowest VC overall.
  always_comb begin
    hi_ok  = 1'b0;
    any_ok = 1'b0;
    hi_vc  = '0;
    any_vc = '0;
    for (int v = NUM_VCS - 1; v >= 0; v--) begin
      if (credit[v] != '0) begin
        any_ok = 1'b1;
        any_vc = VC_BITS'(v);
        if (VC_BITS'(v) >= rr_ptr) begin
          hi_ok = 1'b1;
          hi_vc = VC_BITS'(v);
        end
      end
    end
    pick_ok = any_ok;
    pick_vc = hi_ok ? hi_vc : any_vc;
  end

  always_comb begin
    cur_has_credit = 1'b0;
    cr_inc = '0;
    cr_dec = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (cur_vc == VC_BITS'(v) && credit[v] != '0) cur_has_credit = 1'b1;
      cr_inc[v] = credit_in[VC_BITS] && (credit_in[VC_BITS-1:0] == VC_BITS'(v));
      cr_dec[v] = fire && (cur_vc == VC_BITS'(v));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEND;
      SEND:    if (fire && is_tail) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    fire  = 1'b0;
    case (state)
      IDLE:    start = pending && en && pick_ok;
      SEND:    fire  = en && cur_has_credit;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      pending   <= 1'b0;
      rr_ptr    <= '0;
      cur_vc    <= '0;
      cur_dest  <= '0;
      flit_idx  <= '0;
      pkt_seq   <= '0;
      flit_out  <= '0;
      send_flit <= 1'b0;
      tx_flits  <= '0;
    end else begin
      send_flit <= fire;
      flit_out  <= '0;
      if (en) timer <= wrap ? '0 : timer + 1'b1;
      // A wrap while a request is already outstanding is dropped.
      if (wrap && !pending) pending <= 1'b1;
      else if (start)       pending <= 1'b0;
      if (start) begin
        cur_vc   <= pick_vc;
        cur_dest <= cfg_dest;
        flit_idx <= '0;
        rr_ptr   <= (pick_vc == VC_BITS'(NUM_VCS - 1)) ? '0 : pick_vc + 1'b1;
      end
      if (fire) begin
        flit_out <= {1'b1, is_tail, cur_dest, cur_vc, pkt_seq, flit_idx};
        tx_flits <= tx_flits + 32'd1;
        flit_idx <= flit_idx + 8'd1;
        if (is_tail) pkt_seq <= pkt_seq + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VCS; v++) credit[v] <= CNT_W'(BUF_DEPTH);
      credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (cr_inc[v] && !cr_dec[v]) begin
          if (credit[v] == CNT_W'(BUF_DEPTH)) credit_err <= 1'b1;
          else                                credit[v]  <= credit[v] + 1'b1;
        end else if (cr_dec[v] && !cr_inc[v]) begin
          credit[v] <= credit[v] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_out  <= '0;
      send_credit <= 1'b0;
      rx_flits    <= '0;
    end else begin
      send_credit <= rx_vld;
      credit_out  <= rx_vld ? {1'b1, rx_vc} : '0;
      if (rx_vld) rx_flits <= rx_flits + 32'd1;
    end
  end

`ifdef PE_RX_CHECK_EN
  logic       rx_tail;
  logic [7:0] exp_idx [NUM_VCS];

  assign rx_tail = flit_in[FLIT_W-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VCS; v++) exp_idx[v] <= '0;
      rx_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (rx_vld && rx_vc == VC_BITS'(v)) begin
          if (flit_in[7:0] != exp_idx[v] || rx_tail != (exp_idx[v] == 8'(PKT_LEN - 1)))
            rx_err <= 1'b1;
          exp_idx[v] <= rx_tail ? '0 : exp_idx[v] + 8'd1;
        end
      end
    end
  end
`else
  assign rx_err = 1'b0;
`endif

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Bench for pe_traffic_gen: directed packet/credit/reset sequences, a receive-path vector table, and a randomized run against a transaction-level model.
module tb_pe_traffic_gen;
  localparam int NUM_VCS        = 2;
  localparam int NUM_RECV_PORTS = 16;
  localparam int DATA_WIDTH     = 32;
  localparam int BUF_DEPTH      = 4;
  localparam int PKT_LEN        = 4;
  localparam int INJ_PERIOD     = 20;
  localparam int VC_BITS        = 1;
  localparam int DEST_BITS      = 4;
  localparam int FLIT_W         = 2 + DEST_BITS + VC_BITS + DATA_WIDTH;

`ifdef PE_RX_CHECK_EN
  localparam logic RX_CHECK = 1'b1;
`else
  localparam logic RX_CHECK = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic [DEST_BITS-1:0] cfg_dest;
  logic [FLIT_W-1:0]    flit_in;
  logic [FLIT_W-1:0]    flit_out;
  logic                 send_flit;
  logic [VC_BITS:0]     credit_in;
  logic [VC_BITS:0]     credit_out;
  logic                 send_credit;
  logic [31:0]          tx_flits;
  logic [31:0]          rx_flits;
  logic                 credit_err;
  logic                 rx_err;

  pe_traffic_gen #(
    .NUM_VCS(NUM_VCS), .NUM_RECV_PORTS(NUM_RECV_PORTS), .DATA_WIDTH(DATA_WIDTH),
    .BUF_DEPTH(BUF_DEPTH), .PKT_LEN(PKT_LEN), .INJ_PERIOD(INJ_PERIOD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_dest(cfg_dest), .flit_in(flit_in),
    .flit_out(flit_out), .send_flit(send_flit), .credit_in(credit_in),
    .credit_out(credit_out), .send_credit(send_credit), .tx_flits(tx_flits),
    .rx_flits(rx_flits), .credit_err(credit_err), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       vld;
    logic       vc;
    logic [7:0] idx;
    logic       tail;
    logic       exp_sc;
    logic [1:0] exp_co;
    int         exp_rx;
  } rx_vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input logic tail, input logic [DEST_BITS-1:0] dest,
                                                input logic vc, input logic [23:0] seq, input logic [7:0] idx);
    return {1'b1, tail, dest, vc, seq, idx};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; cfg_dest = '0; flit_in = '0; credit_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns the number of cycles until the next send_flit (or -1 if none within max).
  task automatic wait_flit(input int max, output int waited, output logic [FLIT_W-1:0] fl);
    waited = -1;
    fl = '0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (send_flit) begin
        waited = i;
        fl = flit_out;
        break;
      end
    end
  endtask

  initial begin
    rx_vec_t           vecs [7];
    logic [7:0]        bad_idx [3];
    logic [FLIT_W-1:0] f;
    int                w, fv, tx_cnt, rx_cnt, ex_idx, pkt_vc, v;
    int                mcred [NUM_VCS];
    int                outst [NUM_VCS];
    int                rx_idx [NUM_VCS];
    logic [23:0]       ex_seq;
    logic              cur_en, cur_cr_vld, cur_fl_vld, t;
    int                cur_cr_vc, cur_fl_vc;

    vecs[0] = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 2'b11, 1};
    vecs[1] = '{1'b1, 1'b1, 8'd1, 1'b0, 1'b1, 2'b11, 2};
    vecs[2] = '{1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 2'b11, 3};
    vecs[3] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00, 3};
    vecs[4] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 2'b10, 4};
    vecs[5] = '{1'b1, 1'b1, 8'd3, 1'b1, 1'b1, 2'b11, 5};
    vecs[6] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 2'b00, 5};
    bad_idx[0] = 8'd0; bad_idx[1] = 8'd1; bad_idx[2] = 8'd3;

    // Reset state and the first two packets on VC0 then VC1.
    do_reset();
    check("rst_flit_out", 64'(flit_out), 64'(0));
    check("rst_send_flit", 64'(send_flit), 64'(0));
    check("rst_credit_out", 64'(credit_out), 64'(0));
    check("rst_send_credit", 64'(send_credit), 64'(0));
    check("rst_tx", 64'(tx_flits), 64'(0));
    check("rst_rx", 64'(rx_flits), 64'(0));
    check("rst_credit_err", 64'(credit_err), 64'(0));
    check("rst_rx_err", 64'(rx_err), 64'(0));
    cfg_dest = 4'd3;
    en = 1'b1;
    wait_flit(40, w, f);
    check("a_first_cycle", 64'(w), 64'(22));
    check("a_vc0_flit0", 64'(f), 64'(mk_flit(1'b0, 4'd3, 1'b0, 24'd0, 8'd0)));
    for (int k = 1; k < PKT_LEN; k++) begin
      @(negedge clk);
      check("a_vc0_flit", 64'({send_flit, flit_out}), 64'({1'b1, mk_flit(k == PKT_LEN-1, 4'd3, 1'b0, 24'd0, 8'(k))}));
    end
    wait_flit(40, w, f);
    check("a_second_gap", 64'(w), 64'(17));
    check("a_vc1_flit0", 64'(f), 64'(mk_flit(1'b0, 4'd3, 1'b1, 24'd1, 8'd0)));
    for (int k = 1; k < PKT_LEN; k++) begin
      @(negedge clk);
      check("a_vc1_flit", 64'({send_flit, flit_out}), 64'({1'b1, mk_flit(k == PKT_LEN-1, 4'd3, 1'b1, 24'd1, 8'(k))}));
    end
    check("a_tx8", 64'(tx_flits), 64'(8));
    wait_flit(40, w, f);
    check("a_starved", 64'(w < 0), 64'(1));
    credit_in = 2'b10;
    @(negedge clk);
    credit_in = '0;
    wait_flit(10, w, f);
    check("a_credit_gap", 64'(w), 64'(2));
    check("a_credit_flit", 64'(f), 64'(mk_flit(1'b0, 4'd3, 1'b0, 24'd2, 8'd0)));
    wait_flit(30, w, f);
    check("a_stall_again", 64'(w < 0), 64'(1));
    check("a_tx9", 64'(tx_flits), 64'(9));
    check("a_credit_err", 64'(credit_err), 64'(0));

    // Simultaneous send and return at count 2, then overflow at full.
    do_reset();
    cfg_dest = 4'd5;
    en = 1'b1;
    wait_flit(40, w, f);
    check("b_flit0", 64'(f), 64'(mk_flit(1'b0, 4'd5, 1'b0, 24'd0, 8'd0)));
    @(negedge clk);
    check("b_flit1", 64'({send_flit, flit_out}), 64'({1'b1, mk_flit(1'b0, 4'd5, 1'b0, 24'd0, 8'd1)}));
    credit_in = 2'b10;
    @(negedge clk);
    credit_in = '0;
    check("b_flit2", 64'({send_flit, flit_out}), 64'({1'b1, mk_flit(1'b0, 4'd5, 1'b0, 24'd0, 8'd2)}));
    @(negedge clk);
    check("b_flit3", 64'({send_flit, flit_out}), 64'({1'b1, mk_flit(1'b1, 4'd5, 1'b0, 24'd0, 8'd3)}));
    en = 1'b0;
    repeat (3) begin
      credit_in = 2'b10;
      @(negedge clk);
    end
    credit_in = '0;
    @(negedge clk);
    check("b_no_err_at_full", 64'(credit_err), 64'(0));
    credit_in = 2'b10;
    @(negedge clk);
    credit_in = '0;
    check("b_overflow_err", 64'(credit_err), 64'(1));
    repeat (5) @(negedge clk);
    check("b_err_sticky", 64'(credit_err), 64'(1));
    rst_n = 1'b0;
    #1;
    check("b_err_cleared", 64'(credit_err), 64'(0));

    // Receive path vectors with injection disabled.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      flit_in = vecs[i].vld ? mk_flit(vecs[i].tail, 4'd9, vecs[i].vc, 24'd0, vecs[i].idx) : '0;
      @(negedge clk);
      check("c_send_credit", 64'(send_credit), 64'(vecs[i].exp_sc));
      check("c_credit_out", 64'(credit_out), 64'(vecs[i].exp_co));
      check("c_rx_flits", 64'(rx_flits), 64'(vecs[i].exp_rx));
    end
    flit_in = '0;
    check("c_no_tx", 64'({send_flit, tx_flits}), 64'(0));

    // Asynchronous reset in the middle of a packet.
    do_reset();
    cfg_dest = 4'd7;
    en = 1'b1;
    wait_flit(40, w, f);
    @(negedge clk);
    check("d_pre_flit1", 64'({send_flit, flit_out}), 64'({1'b1, mk_flit(1'b0, 4'd7, 1'b0, 24'd0, 8'd1)}));
    rst_n = 1'b0;
    #1;
    check("d_rst_flit_out", 64'(flit_out), 64'(0));
    check("d_rst_send", 64'(send_flit), 64'(0));
    check("d_rst_tx", 64'(tx_flits), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wait_flit(40, w, f);
    check("d_restart_cycle", 64'(w), 64'(22));
    check("d_restart_flit0", 64'(f), 64'(mk_flit(1'b0, 4'd7, 1'b0, 24'd0, 8'd0)));
    for (int k = 1; k < PKT_LEN; k++) begin
      @(negedge clk);
      check("d_restart_flit", 64'({send_flit, flit_out}), 64'({1'b1, mk_flit(k == PKT_LEN-1, 4'd7, 1'b0, 24'd0, 8'(k))}));
    end

    // Receive-order checker: bad then good sequences on VC0.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      flit_in = mk_flit(1'b0, 4'd1, 1'b0, 24'd0, bad_idx[i]);
      @(negedge clk);
      check("e_bad_seq_err", 64'(rx_err), 64'((i == 2) ? RX_CHECK : 1'b0));
    end
    flit_in = '0;
    do_reset();
    for (int i = 0; i < PKT_LEN; i++) begin
      flit_in = mk_flit(i == PKT_LEN-1, 4'd1, 1'b0, 24'd0, 8'(i));
      @(negedge clk);
      check("e_good_seq_err", 64'(rx_err), 64'(0));
    end
    flit_in = '0;
    check("e_good_rx", 64'(rx_flits), 64'(PKT_LEN));

    // Randomized run against a transaction-level model.
    do_reset();
    cfg_dest = 4'($urandom_range(0, 15));
    en = 1'b1;
    for (int i = 0; i < NUM_VCS; i++) begin
      mcred[i] = BUF_DEPTH; outst[i] = 0; rx_idx[i] = 0;
    end
    tx_cnt = 0; rx_cnt = 0; ex_idx = 0; ex_seq = '0; pkt_vc = 0;
    cur_en = 1'b1; cur_cr_vld = 1'b0; cur_cr_vc = 0; cur_fl_vld = 1'b0; cur_fl_vc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (send_flit) begin
        fv = int'(flit_out[DATA_WIDTH]);
        check("r_en_gate", 64'(cur_en), 64'(1));
        check("r_credit_avail", 64'(mcred[fv] > 0), 64'(1));
        if (ex_idx == 0) pkt_vc = fv;
        check("r_flit", 64'(flit_out), 64'(mk_flit(ex_idx == PKT_LEN-1, cfg_dest, 1'(pkt_vc), ex_seq, 8'(ex_idx))));
        mcred[fv]--;
        outst[fv]++;
        tx_cnt++;
        if (ex_idx == PKT_LEN-1) begin
          ex_idx = 0;
          ex_seq++;
        end else begin
          ex_idx++;
        end
      end else begin
        check("r_idle_zero", 64'(flit_out), 64'(0));
      end
      if (cur_cr_vld) mcred[cur_cr_vc]++;
      check("r_send_credit", 64'(send_credit), 64'(cur_fl_vld));
      check("r_credit_out", 64'(credit_out), 64'(cur_fl_vld ? {1'b1, 1'(cur_fl_vc)} : 2'b00));
      if (cur_fl_vld) rx_cnt++;
      check("r_rx", 64'(rx_flits), 64'(rx_cnt));
      check("r_tx", 64'(tx_flits), 64'(tx_cnt));

      en = ($urandom_range(0, 9) < 8);
      cur_cr_vld = 1'b0;
      credit_in = '0;
      if (outst[0] + outst[1] > 0 && $urandom_range(0, 2) == 0) begin
        v = int'($urandom_range(0, 1));
        if (outst[v] == 0) v = 1 - v;
        outst[v]--;
        credit_in = {1'b1, 1'(v)};
        cur_cr_vld = 1'b1;
        cur_cr_vc = v;
      end
      cur_fl_vld = 1'b0;
      flit_in = '0;
      if ($urandom_range(0, 9) < 3) begin
        v = int'($urandom_range(0, 1));
        t = (rx_idx[v] == PKT_LEN-1);
        flit_in = mk_flit(t, 4'($urandom_range(0, 15)), 1'(v), 24'($urandom), 8'(rx_idx[v]));
        rx_idx[v] = t ? 0 : rx_idx[v] + 1;
        cur_fl_vld = 1'b1;
        cur_fl_vc = v;
      end
      cur_en = en;
    end
    en = 1'b0;
    credit_in = '0;
    flit_in = '0;
    @(negedge clk);
    check("r_credit_err", 64'(credit_err), 64'(0));
    check("r_rx_err", 64'(rx_err), 64'(0));
    check("r_progress", 64'(tx_cnt > 20), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
